exp_mul_sched: RTL and testbench

Round-robin scheduler that shares one exponent-multiplier engine (15-bit fixed-point X in; six 26-bit multipliers and a completion pulse out) among several requesters. It accepts one request at a time and drives the engine's X and single-cycle valid. It collects the six multipliers on completion, or on a watchdog timeout if the engine terminates early without pulsing. It then returns the result with the requester's ID over a valid/ready response port.

---
 rtl/exp_mul_sched.sv | 135 +++++++++++++
 tb/tb_exp_mul_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/exp_mul_sched.sv
// Round-robin scheduler sharing one exponent-multiplier engine among N_REQ requesters.
// Latency: accept in IDLE, eng_valid next cycle, response one cycle after pulse or watchdog.
// Backpressure: one request in flight; response held in RESP until rsp_ready, req_valid ignored meanwhile.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_x/req_ready        per-requester request, 15-bit X, one-hot accept strobe
//   eng_x/eng_valid                  X and single-cycle start pulse to the engine
//   eng_mul_valid/eng_mul            engine completion pulse and six 26-bit multipliers
//   rsp_valid/rsp_ready/rsp_id/      response handshake, requester index,
//   rsp_timeout/rsp_data             watchdog flag and captured multipliers
//   busy, timeout_cnt                not-IDLE flag, saturating watchdog event count
module exp_mul_sched #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 32,
  localparam int IW     = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [15*N_REQ-1:0]  req_x,
  output logic [N_REQ-1:0]     req_ready,
  output logic [14:0]          eng_x,
  output logic                 eng_valid,
  input  logic                 eng_mul_valid,
  input  logic [155:0]         eng_mul,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic                 rsp_timeout,
  output logic [155:0]         rsp_data,
  output logic                 busy,
  output logic [7:0]           timeout_cnt
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   id_q;
  logic [14:0]     x_q;
  logic [TW-1:0]   timer;
  logic            timer_done;

  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  logic [14:0]     grant_x;

  assign timer_done = (timer == TW'(TIMEOUT - 1));

  // Round-robin search starting just after the last winner.
  always_comb begin : arb
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_x   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(cand);
        grant_x   = req_x[cand*15 +: 15];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req_ready[grant_idx] = 1'b1;
          state_nxt            = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT:  if (eng_mul_valid || timer_done) state_nxt = RESP;
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign eng_valid = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  // x_q only changes on acceptance, so the engine sees a stable X for the whole run.
  assign eng_x     = x_q;
  assign rsp_id    = id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= IW'(N_REQ - 1);
      id_q        <= '0;
      x_q         <= '0;
      timer       <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            ptr  <= grant_idx;
            id_q <= grant_idx;
            x_q  <= grant_x;
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          timer <= timer + 1'b1;
          // A completion pulse on the watchdog's last cycle still counts as a clean finish.
          if (eng_mul_valid) begin
            rsp_data    <= eng_mul;
            rsp_timeout <= 1'b0;
          end else if (timer_done) begin
            rsp_data    <= eng_mul;
            rsp_timeout <= 1'b1;
            if (timeout_cnt != 8'hff) timeout_cnt <= timeout_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_mul_sched.sv
module tb_exp_mul_sched;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [59:0]   req_x;
  logic [3:0]    req_ready;
  logic [14:0]   eng_x;
  logic          eng_valid;
  logic          eng_mul_valid;
  logic [155:0]  eng_mul;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic          rsp_timeout;
  logic [155:0]  rsp_data;
  logic          busy;
  logic [7:0]    timeout_cnt;

  exp_mul_sched #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .eng_x(eng_x), .eng_valid(eng_valid),
    .eng_mul_valid(eng_mul_valid), .eng_mul(eng_mul),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_timeout(rsp_timeout), .rsp_data(rsp_data),
    .busy(busy), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Transaction-level model state (what the outputs must currently show).
  int           m_ptr;
  logic [1:0]   m_id;
  logic [14:0]  m_x;
  logic         m_to;
  logic [155:0] m_data;
  int           m_tcnt;

  // Observations of the last transaction, for literal checks.
  logic [1:0]   last_id;
  logic         last_to;
  logic [155:0] last_data;
  int           last_lat;

  task automatic chk(input string name, input logic [155:0] got, input logic [155:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input logic [3:0] e_rr, input logic e_ev, input logic e_rv, input logic e_busy);
    chk("req_ready", 156'(req_ready), 156'(e_rr));
    chk("eng_valid", 156'(eng_valid), 156'(e_ev));
    chk("eng_x", 156'(eng_x), 156'(m_x));
    chk("rsp_valid", 156'(rsp_valid), 156'(e_rv));
    chk("rsp_id", 156'(rsp_id), 156'(m_id));
    chk("rsp_timeout", 156'(rsp_timeout), 156'(m_to));
    chk("rsp_data", rsp_data, m_data);
    chk("busy", 156'(busy), 156'(e_busy));
    chk("timeout_cnt", 156'(timeout_cnt), 156'(m_tcnt));
  endtask

  function automatic logic [155:0] rnd156();
    logic [159:0] v;
    for (int i = 0; i < 5; i++) v[i*32 +: 32] = $urandom;
    return v[155:0];
  endfunction

  function automatic logic [59:0] rnd60();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[59:0];
  endfunction

  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int k = 1; k <= N_REQ; k++)
      if (mask[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    return -1;
  endfunction

  function automatic logic [155:0] pack_mul(input int m0, input int m1, input int m2,
                                            input int m3, input int m4, input int m5);
    return {26'(m5), 26'(m4), 26'(m3), 26'(m2), 26'(m1), 26'(m0)};
  endfunction

  // Asserts reset at the current point; leaves time at posedge+1 with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_x = '0; eng_mul_valid = 1'b0; eng_mul = '0; rsp_ready = 1'b0;
    m_ptr = N_REQ - 1; m_id = '0; m_x = '0; m_to = 1'b0; m_data = '0; m_tcnt = 0;
    #1;
    check_all(4'b0000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle(input int n, input logic stray);
    for (int k = 0; k < n; k++) begin
      req_valid = '0;
      req_x = rnd60();
      eng_mul_valid = stray;
      eng_mul = rnd156();
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_all(4'b0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    eng_mul_valid = 1'b0;
  endtask

  // One request from acceptance to handshake. d = pulse offset after eng_valid (0 = none);
  // w = cycles rsp_ready stays low in RESP; abort_k >= 0 resets at that cycle.
  task automatic txn(input logic [3:0] mask, input logic [59:0] xv, input logic [3:0] hold,
                     input int d, input logic [155:0] mul, input int w, input int abort_k);
    int g, c, last, ev_k, rv_k;
    logic to, pulses;
    g = rr_pick(mask, m_ptr);
    pulses = (d > 0) && (d <= TIMEOUT);
    c = 1 + (pulses ? d : TIMEOUT);
    to = !pulses;
    last = c + 1 + w;
    ev_k = -1; rv_k = -1;
    for (int k = 0; k <= last; k++) begin
      if (k == abort_k) begin
        do_reset();
        last_lat = -1;
        return;
      end
      req_valid = (k == 0) ? mask : hold;
      req_x = (k == 0) ? xv : rnd60();
      eng_mul_valid = (d > 0) && (k == 1 + d);
      eng_mul = (k == c) ? mul : rnd156();
      rsp_ready = (k == last) || ((k <= c) && 1'($urandom_range(0, 1)));
      @(negedge clk);
      check_all((k == 0) ? 4'(1 << g) : 4'b0000, k == 1, k > c, k > 0);
      if (eng_valid && ev_k < 0) ev_k = k;
      if (rsp_valid && rv_k < 0) rv_k = k;
      if (k == last) begin
        last_id = rsp_id; last_to = rsp_timeout; last_data = rsp_data;
      end
      @(posedge clk); #1;
      if (k == 0) begin
        m_ptr = g; m_id = 2'(g); m_x = xv[15*g +: 15];
      end
      if (k == c) begin
        m_data = mul; m_to = to;
        if (to && m_tcnt < 255) m_tcnt++;
      end
    end
    eng_mul_valid = 1'b0;
    last_lat = (ev_k >= 0 && rv_k >= 0) ? rv_k - ev_k : -1;
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    logic [59:0] xv;
    int d;

    do_reset();

    // Single request: X=1.0, multipliers 1..6 after a full-length run.
    xv = rnd60();
    xv[14:0] = 15'h0800;
    txn(4'b0001, xv, 4'b0000, 20, pack_mul(1, 2, 3, 4, 5, 6), 0, -1);
    chk("single_id", 156'(last_id), 156'(0));
    chk("single_to", 156'(last_to), 156'(0));
    chk("single_data", last_data, {26'd6, 26'd5, 26'd4, 26'd3, 26'd2, 26'd1});
    chk("single_lat", 156'(last_lat), 156'(21));

    // All requesters pending: grant order rotates from 0 after reset.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, rnd60(), 4'b1111, 20, rnd156(), 0, -1);
      chk("rr_order", 156'(last_id), 156'(order[i]));
    end

    // Watchdog: no pulse, then saturate the event counter.
    do_reset();
    txn(4'b0100, rnd60(), 4'b0000, 0, rnd156(), 0, -1);
    chk("wd_id", 156'(last_id), 156'(2));
    chk("wd_to", 156'(last_to), 156'(1));
    chk("wd_lat", 156'(last_lat), 156'(TIMEOUT + 1));
    chk("wd_cnt1", 156'(timeout_cnt), 156'(1));
    for (int i = 0; i < 259; i++)
      txn(4'($urandom_range(1, 15)), rnd60(), 4'($urandom), 0, rnd156(), 0, -1);
    chk("wd_cnt_sat", 156'(timeout_cnt), 156'(255));

    // Stalled response with another requester waiting; it wins right after the handshake.
    txn(4'b0001, rnd60(), 4'b0010, 20, rnd156(), 10, -1);
    chk("stall_id0", 156'(last_id), 156'(0));
    txn(4'b0010, rnd60(), 4'b0000, 20, rnd156(), 0, -1);
    chk("stall_id1", 156'(last_id), 156'(1));

    // Pulse coincides with the watchdog's last cycle: clean completion.
    txn(4'b1000, rnd60(), 4'b0000, TIMEOUT, rnd156(), 0, -1);
    chk("tie_to", 156'(last_to), 156'(0));
    chk("tie_lat", 156'(last_lat), 156'(TIMEOUT + 1));
    idle(5, 1'b1);

    // Reset mid-WAIT, then a late engine pulse must not produce a response.
    txn(4'b0001, rnd60(), 4'b0000, 20, rnd156(), 0, 5);
    chk("abort_tcnt", 156'(timeout_cnt), 156'(0));
    idle(30, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: d = 0;
        1: d = 20;
        2: d = $urandom_range(1, TIMEOUT);
        default: d = $urandom_range(TIMEOUT + 1, TIMEOUT + 4);
      endcase
      txn(4'($urandom_range(1, 15)), rnd60(), 4'($urandom), d, rnd156(),
          $urandom_range(0, 4), -1);
      idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
